// File: rtl/byte_word_unpacker_if.sv
// Handshake bundle between a word producer, the unpacker and an element consumer.
// The slave modport is the unpacker's view of the bundle.
interface byte_word_unpacker_if #(
  parameter int WORD_W = 32,
  parameter int NIB_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [NIB_W-1:0]  out_nibble;
  logic [2:0]        out_index;
  logic              out_first;
  logic              out_last;
  logic              word_rep;
  logic              word_all1;
  logic              word_par;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_nibble, out_index, out_first, out_last,
           word_rep, word_all1, word_par
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_nibble, out_index, out_first, out_last,
           word_rep, word_all1, word_par
  );
endinterface

// File: rtl/byte_word_unpacker.sv
// Splits each WORD_W input word into NUM elements of NIB_W bits, most-significant first,
// with zero-bubble back-to-back word acceptance and per-word replication/all-ones/parity flags.
module byte_word_unpacker #(
  parameter int WORD_W = 32,
  parameter int NIB_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  byte_word_unpacker_if.slave   bus
);
  localparam int NUM = WORD_W / NIB_W;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]        state;
  logic [WORD_W-1:0] hold;
  logic [WORD_W-1:0] shifted;
  logic [2:0]        idx;
  logic              rep;
  logic              all1;
  logic              par;

  logic valid;
  logic last;
  logic take_out;
  logic rdy;
  logic take_in;
  logic rep_in;

  always_comb begin
    valid    = (state == SHIFT);
    last     = valid && (idx == 3'(NUM - 1));
    take_out = valid && bus.out_ready;
    // accepting on the last beat lets the next word follow with no idle cycle
    rdy      = (state == IDLE) || (take_out && last);
    take_in  = bus.in_valid && rdy;
    rep_in   = (bus.in_data == {NUM{bus.in_data[WORD_W-1 -: NIB_W]}});
    shifted  = hold << (NIB_W * idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hold  <= '0;
      idx   <= '0;
      rep   <= 1'b0;
      all1  <= 1'b0;
      par   <= 1'b0;
    end else if (take_in) begin
      state <= SHIFT;
      hold  <= bus.in_data;
      idx   <= '0;
      rep   <= rep_in;
      all1  <= &bus.in_data;
      par   <= ^bus.in_data;
    end else if (take_out) begin
      if (last) begin
        state <= IDLE;
        idx   <= '0;
      end else begin
        idx   <= idx + 3'd1;
      end
    end
  end

  assign bus.in_ready   = rdy;
  assign bus.out_valid  = valid;
  assign bus.out_nibble = shifted[WORD_W-1 -: NIB_W];
  assign bus.out_index  = idx;
  assign bus.out_first  = valid && (idx == 3'd0);
  assign bus.out_last   = last;
  assign bus.word_rep   = rep;
  assign bus.word_all1  = all1;
  assign bus.word_par   = par;
endmodule
